// File: rtl/vx_flush_req_mux_pkg.sv
// Shared types and default sizes for the bank input stage (flush/core request mux).
package vx_flush_req_mux_pkg;

    localparam int DEF_LINE_SEL_BITS    = 8;
    localparam int DEF_LINE_ADDR_WIDTH  = 26;
    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_TAG_WIDTH        = 8;
    localparam int DEF_FLUSH_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        FLUSH_ST_INIT  = 2'd0,
        FLUSH_ST_FLUSH = 2'd1,
        FLUSH_ST_DRAIN = 2'd2,
        FLUSH_ST_RUN   = 2'd3
    } flush_state_e;

endpackage

// File: rtl/vx_flush_req_mux_if.sv
// Core request handshake plus the registered request slot toward the tag-access stage.
interface vx_flush_req_mux_if #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 8
);
    logic                       core_req_valid;
    logic                       core_req_rw;
    logic [LINE_ADDR_WIDTH-1:0] core_req_addr;
    logic [DATA_WIDTH-1:0]      core_req_data;
    logic [TAG_WIDTH-1:0]       core_req_tag;
    logic                       core_req_ready;

    logic                       pipe_valid_out;
    logic                       pipe_is_flush;
    logic                       pipe_rw;
    logic [LINE_ADDR_WIDTH-1:0] pipe_addr;
    logic [DATA_WIDTH-1:0]      pipe_data;
    logic [TAG_WIDTH-1:0]       pipe_tag;
    logic                       pipe_ready_in;

    modport master (
        output core_req_valid, core_req_rw, core_req_addr, core_req_data, core_req_tag,
        input  core_req_ready,
        input  pipe_valid_out, pipe_is_flush, pipe_rw, pipe_addr, pipe_data, pipe_tag,
        output pipe_ready_in
    );

    modport slave (
        input  core_req_valid, core_req_rw, core_req_addr, core_req_data, core_req_tag,
        output core_req_ready,
        output pipe_valid_out, pipe_is_flush, pipe_rw, pipe_addr, pipe_data, pipe_tag,
        input  pipe_ready_in
    );
endinterface

// File: rtl/vx_flush_fifo.sv
// Register FIFO buffering flush line indices; the caller never pushes a full FIFO
// without a same-cycle pop and never pops an empty one.
module vx_flush_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    // Storage, pointers (wrap naturally since DEPTH is a power of 2) and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == {(AW+1){1'b0}});
    assign full  = (count_r == (AW+1)'(DEPTH));
endmodule

// File: rtl/vx_flush_req_mux.sv
// Bank input stage: merges buffered flush ops and core requests into one registered slot,
// holding core traffic off until every flush op since reset has been handed downstream.
module vx_flush_req_mux
    import vx_flush_req_mux_pkg::*;
#(
    parameter int LINE_SEL_BITS    = DEF_LINE_SEL_BITS,
    parameter int LINE_ADDR_WIDTH  = DEF_LINE_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH        = DEF_TAG_WIDTH,
    parameter int FLUSH_FIFO_DEPTH = DEF_FLUSH_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_valid_in,
    input  logic [LINE_SEL_BITS-1:0] flush_addr_in,
    vx_flush_req_mux_if.slave        bus,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     flush_overflow
);
    flush_state_e             state_r;
    flush_state_e             state_s;
    logic                     load_s;
    logic                     fifo_push_s;
    logic                     fifo_pop_s;
    logic                     fifo_empty_s;
    logic                     fifo_full_s;
    logic [LINE_SEL_BITS-1:0] fifo_dout_s;
    logic                     bypass_s;
    logic                     drop_s;
    logic                     core_ready_s;
    logic                     core_accept_s;
    logic                     slot_flush_held_s;

    vx_flush_fifo #(
        .WIDTH (LINE_SEL_BITS),
        .DEPTH (FLUSH_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (flush_addr_in),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // The FIFO head always wins the slot; a new flush op only bypasses when nothing is queued
    assign load_s        = !bus.pipe_valid_out | bus.pipe_ready_in;
    assign fifo_pop_s    = load_s & !fifo_empty_s;
    assign bypass_s      = load_s & fifo_empty_s & flush_valid_in;
    assign fifo_push_s   = flush_valid_in & !bypass_s & (!fifo_full_s | fifo_pop_s);
    assign drop_s        = flush_valid_in & !bypass_s & fifo_full_s & !fifo_pop_s;
    assign core_ready_s  = (state_r == FLUSH_ST_RUN) & !flush_valid_in & fifo_empty_s & load_s;
    assign core_accept_s = core_ready_s & bus.core_req_valid;
    assign slot_flush_held_s = bus.pipe_valid_out & bus.pipe_is_flush & !bus.pipe_ready_in;

    assign bus.core_req_ready = core_ready_s;
    assign flush_busy         = (state_r != FLUSH_ST_RUN);

    // Output slot: reloads only when empty or being accepted, otherwise holds stable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pipe_valid_out <= 1'b0;
            bus.pipe_is_flush  <= 1'b0;
            bus.pipe_rw        <= 1'b0;
            bus.pipe_addr      <= {LINE_ADDR_WIDTH{1'b0}};
            bus.pipe_data      <= {DATA_WIDTH{1'b0}};
            bus.pipe_tag       <= {TAG_WIDTH{1'b0}};
        end else if (load_s) begin
            if (fifo_pop_s || bypass_s) begin
                bus.pipe_valid_out <= 1'b1;
                bus.pipe_is_flush  <= 1'b1;
                bus.pipe_rw        <= 1'b0;
                bus.pipe_addr      <= fifo_pop_s ? LINE_ADDR_WIDTH'(fifo_dout_s)
                                                 : LINE_ADDR_WIDTH'(flush_addr_in);
                bus.pipe_data      <= {DATA_WIDTH{1'b0}};
                bus.pipe_tag       <= {TAG_WIDTH{1'b0}};
            end else if (core_accept_s) begin
                bus.pipe_valid_out <= 1'b1;
                bus.pipe_is_flush  <= 1'b0;
                bus.pipe_rw        <= bus.core_req_rw;
                bus.pipe_addr      <= bus.core_req_addr;
                bus.pipe_data      <= bus.core_req_data;
                bus.pipe_tag       <= bus.core_req_tag;
            end else begin
                bus.pipe_valid_out <= 1'b0;
                bus.pipe_is_flush  <= 1'b0;
                bus.pipe_rw        <= 1'b0;
                bus.pipe_addr      <= {LINE_ADDR_WIDTH{1'b0}};
                bus.pipe_data      <= {DATA_WIDTH{1'b0}};
                bus.pipe_tag       <= {TAG_WIDTH{1'b0}};
            end
        end
    end

    // Sticky record of any flush op lost to a full buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_overflow <= 1'b0;
        end else if (drop_s) begin
            flush_overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FLUSH_ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; a core op left in the slot does not block the DRAIN->RUN exit
    always_comb begin
        state_s    = state_r;
        flush_done = 1'b0;
        case (state_r)
            FLUSH_ST_INIT: begin
                if (flush_valid_in) state_s = FLUSH_ST_FLUSH;
                else                state_s = FLUSH_ST_INIT;
            end
            FLUSH_ST_FLUSH: begin
                if (!flush_valid_in) state_s = FLUSH_ST_DRAIN;
                else                 state_s = FLUSH_ST_FLUSH;
            end
            FLUSH_ST_DRAIN: begin
                if (flush_valid_in) begin
                    state_s = FLUSH_ST_FLUSH;
                end else if (fifo_empty_s && !slot_flush_held_s) begin
                    state_s    = FLUSH_ST_RUN;
                    flush_done = 1'b1;
                end else begin
                    state_s = FLUSH_ST_DRAIN;
                end
            end
            FLUSH_ST_RUN: begin
                if (flush_valid_in) state_s = FLUSH_ST_FLUSH;
                else                state_s = FLUSH_ST_RUN;
            end
            default: state_s = FLUSH_ST_INIT;
        endcase
    end
endmodule

// File: tb/tb_vx_flush_req_mux.sv
// Scenario bench for vx_flush_req_mux: per-scenario tasks plus an in-order slot scoreboard.
module tb_vx_flush_req_mux;
    localparam int LSB = 8;
    localparam int LAW = 26;
    localparam int DW  = 32;
    localparam int TW  = 8;

    typedef struct packed {
        logic           is_flush;
        logic           rw;
        logic [LAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [TW-1:0]  tag;
    } item_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush_valid_in;
    logic [LSB-1:0] flush_addr_in;
    logic           flush_busy;
    logic           flush_done;
    logic           flush_overflow;

    item_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    vx_flush_req_mux_if #(.LINE_ADDR_WIDTH(LAW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

    vx_flush_req_mux #(
        .LINE_SEL_BITS    (LSB),
        .LINE_ADDR_WIDTH  (LAW),
        .DATA_WIDTH       (DW),
        .TAG_WIDTH        (TW),
        .FLUSH_FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_valid_in (flush_valid_in),
        .flush_addr_in  (flush_addr_in),
        .bus            (bus.slave),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .flush_overflow (flush_overflow)
    );

    always #5 clk = ~clk;

    function automatic item_t mk_flush(input int a);
        item_t it;
        it = '0;
        it.is_flush = 1'b1;
        it.addr = LAW'(a);
        return it;
    endfunction

    function automatic item_t cur_slot();
        return {bus.pipe_is_flush, bus.pipe_rw, bus.pipe_addr, bus.pipe_data, bus.pipe_tag};
    endfunction

    // One clock: mid-cycle, score any slot being accepted; return just after the edge
    task automatic tick();
        item_t e;
        item_t got;
        @(negedge clk);
        if (bus.pipe_valid_out && bus.pipe_ready_in) begin
            checks++;
            got = cur_slot();
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_slot got=%h exp=%h", got, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic rw, input int a, input int d, input int t);
        bus.core_req_rw   = rw;
        bus.core_req_addr = LAW'(a);
        bus.core_req_data = DW'(d);
        bus.core_req_tag  = TW'(t);
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (flush_busy && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (flush_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout flush_busy=%b exp=0", name, flush_busy);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        flush_valid_in = 1'b0;
        bus.core_req_valid = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush_valid_in = 1'b0;
        flush_addr_in = '0;
        bus.core_req_valid = 1'b1;
        drive_core(1'b1, 5, 5, 5);
        bus.pipe_ready_in = 1'b1;
        #2;
        checks++;
        if ({bus.pipe_valid_out, bus.pipe_is_flush, bus.pipe_addr, bus.pipe_tag} !== '0) begin
            failures++;
            $display("FAIL reset_pipe got=%b/%b/%h/%h exp=0", bus.pipe_valid_out,
                     bus.pipe_is_flush, bus.pipe_addr, bus.pipe_tag);
        end
        checks++;
        if ({flush_busy, flush_done, flush_overflow, bus.core_req_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=1000",
                     {flush_busy, flush_done, flush_overflow, bus.core_req_ready});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({flush_busy, bus.core_req_ready, bus.pipe_valid_out} !== 3'b100) begin
            failures++;
            $display("FAIL init_hold got=%b exp=100",
                     {flush_busy, bus.core_req_ready, bus.pipe_valid_out});
        end
        bus.core_req_valid = 1'b0;
    endtask

    task automatic test_flush_basic();
        reset_dut();
        bus.pipe_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            flush_valid_in = 1'b1;
            flush_addr_in  = LSB'(i);
            exp_q.push_back(mk_flush(i));
            tick();
            checks++;
            if (!bus.pipe_valid_out || !bus.pipe_is_flush || bus.pipe_addr !== LAW'(i)) begin
                failures++;
                $display("FAIL basic_slot%0d got=%b/%b/%h exp=1/1/%h", i, bus.pipe_valid_out,
                         bus.pipe_is_flush, bus.pipe_addr, LAW'(i));
            end
        end
        flush_valid_in = 1'b0;
        #1;
        checks++;
        if (flush_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_early got=%b exp=0", flush_done);
        end
        tick();
        checks++;
        if (flush_done !== 1'b1 || bus.pipe_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got=%b/%b exp=1/0", flush_done, bus.pipe_valid_out);
        end
        tick();
        checks++;
        if ({flush_done, flush_busy, bus.core_req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL basic_run got=%b exp=001", {flush_done, flush_busy, bus.core_req_ready});
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        bus.pipe_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush_valid_in = 1'b1;
            flush_addr_in  = LSB'(i);
            exp_q.push_back(mk_flush(i));
            tick();
        end
        flush_valid_in = 1'b0;
        tick();
        tick();
        checks++;
        if (!bus.pipe_valid_out || bus.pipe_addr !== LAW'(0) || flush_overflow !== 1'b0 || !flush_busy) begin
            failures++;
            $display("FAIL bp_hold got=%b/%h/%b/%b exp=1/0/0/1", bus.pipe_valid_out,
                     bus.pipe_addr, flush_overflow, flush_busy);
        end
        bus.pipe_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (!bus.pipe_valid_out || bus.pipe_addr !== LAW'(k)) begin
                failures++;
                $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", k, bus.pipe_valid_out,
                         bus.pipe_addr, LAW'(k));
            end
            tick();
        end
        wait_run("bp");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        bus.pipe_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            flush_valid_in = 1'b1;
            flush_addr_in  = LSB'(i);
            if (i < 5) exp_q.push_back(mk_flush(i));
            tick();
        end
        flush_valid_in = 1'b0;
        checks++;
        if (flush_overflow !== 1'b1 || bus.pipe_addr !== LAW'(0)) begin
            failures++;
            $display("FAIL ovf_flag got=%b/%h exp=1/0", flush_overflow, bus.pipe_addr);
        end
        bus.pipe_ready_in = 1'b1;
        wait_run("ovf");
        tick();
        checks++;
        if (flush_overflow !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_after got=%b/%0d exp=1/0", flush_overflow, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        int    k;
        int    c;
        logic  acc;
        logic  hold;
        item_t snap;
        item_t it;
        reset_dut();
        bus.pipe_ready_in = 1'b1;
        flush_valid_in = 1'b1;
        flush_addr_in  = LSB'(9);
        exp_q.push_back(mk_flush(9));
        tick();
        flush_valid_in = 1'b0;
        wait_run("b2b_setup");
        pat = 4'b1101;
        k = 0;
        c = 0;
        while ((k < 4 || exp_q.size() != 0) && c < 40) begin
            bus.pipe_ready_in  = pat[c % 4];
            bus.core_req_valid = (k < 4);
            drive_core(1'b1, 32'hA0 + k, 32'hD000 + k, k + 1);
            #1;
            acc = bus.core_req_valid & bus.core_req_ready;
            if (acc) begin
                it = {1'b0, 1'b1, LAW'(32'hA0 + k), DW'(32'hD000 + k), TW'(k + 1)};
                exp_q.push_back(it);
            end
            hold = bus.pipe_valid_out & !bus.pipe_ready_in;
            snap = cur_slot();
            tick();
            if (hold) begin
                checks++;
                if (cur_slot() !== snap || !bus.pipe_valid_out) begin
                    failures++;
                    $display("FAIL b2b_stable got=%h exp=%h", cur_slot(), snap);
                end
            end
            if (acc) k++;
            c++;
        end
        bus.core_req_valid = 1'b0;
        checks++;
        if (k != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d/%0d exp=4/0", k, exp_q.size());
        end
    endtask

    task automatic test_flush_preempt();
        int    t;
        logic  acc;
        item_t it;
        bus.pipe_ready_in = 1'b1;
        t = 0;
        for (int c = 0; c < 3; c++) begin
            bus.core_req_valid = 1'b1;
            drive_core(1'b0, 32'h200 + t, 32'hB0 + t, 32'h20 + t);
            #1;
            acc = bus.core_req_ready;
            if (acc) begin
                it = {1'b0, 1'b0, LAW'(32'h200 + t), DW'(32'hB0 + t), TW'(32'h20 + t)};
                exp_q.push_back(it);
                t++;
            end
            tick();
        end
        drive_core(1'b0, 32'h200 + t, 32'hB0 + t, 32'h20 + t);
        flush_valid_in = 1'b1;
        flush_addr_in  = LSB'(0);
        #1;
        checks++;
        if (bus.core_req_ready !== 1'b0 || !bus.pipe_valid_out || bus.pipe_is_flush !== 1'b0) begin
            failures++;
            $display("FAIL pre_block got=%b/%b/%b exp=0/1/0", bus.core_req_ready,
                     bus.pipe_valid_out, bus.pipe_is_flush);
        end
        exp_q.push_back(mk_flush(0));
        tick();
        flush_valid_in = 1'b0;
        bus.core_req_valid = 1'b0;
        checks++;
        if (!bus.pipe_is_flush || bus.pipe_addr !== LAW'(0) || !flush_busy) begin
            failures++;
            $display("FAIL pre_flush got=%b/%h/%b exp=1/0/1", bus.pipe_is_flush,
                     bus.pipe_addr, flush_busy);
        end
        wait_run("pre");
        tick();
        checks++;
        if (exp_q.size() != 0 || t != 3) begin
            failures++;
            $display("FAIL pre_left got=%0d/%0d exp=0/3", exp_q.size(), t);
        end
    endtask

    task automatic test_reset_midflush();
        reset_dut();
        bus.pipe_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush_valid_in = 1'b1;
            flush_addr_in  = LSB'(i + 1);
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pipe_valid_out !== 1'b0 || flush_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_async got=%b/%b exp=0/1", bus.pipe_valid_out, flush_busy);
        end
        exp_q.delete();
        flush_valid_in = 1'b0;
        bus.pipe_ready_in = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pipe_valid_out !== 1'b0 || bus.core_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_empty got=%b/%b exp=0/0", bus.pipe_valid_out, bus.core_req_ready);
        end
        flush_valid_in = 1'b1;
        flush_addr_in  = LSB'(7);
        exp_q.push_back(mk_flush(7));
        tick();
        flush_valid_in = 1'b0;
        checks++;
        if (bus.pipe_addr !== LAW'(7) || !bus.pipe_valid_out) begin
            failures++;
            $display("FAIL mid_fifo_clear got=%b/%h exp=1/7", bus.pipe_valid_out, bus.pipe_addr);
        end
        wait_run("mid");
    endtask

    initial begin
        test_reset();
        test_flush_basic();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_flush_preempt();
        test_reset_midflush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
